// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter: FSM encodings and requester id.
// No logic of its own; imported by dmem_rr_arb2 and dmem_arbiter.
// Round-robin versus fixed priority is selected by DMEM_ARB_RR_EN in dmem_rr_arb2.
package dmem_arb_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'b00;
    localparam logic [1:0] ENC_ACCESS = 2'b01;
    localparam logic [1:0] ENC_RESP   = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = ENC_IDLE,
        ACCESS = ENC_ACCESS,
        RESP   = ENC_RESP
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way grant logic; round-robin with DMEM_ARB_RR_EN defined, else requester 0 wins ties.
// Latency: combinational grant; the pointer moves on the clock edge of each grant.
// Backpressure: grants only while en is high; a grant is the handshake (ready == grant).
module dmem_rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1,
    output logic grant_id
);

`ifdef DMEM_ARB_RR_EN
    req_id_t ptr;

    always_comb begin
        grant_id = REQ0;
        if (valid0 && valid1) begin
            grant_id = ptr;
        end else if (valid1) begin
            grant_id = REQ1;
        end
    end

    // After every grant the other requester gets the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= REQ0;
        end else if (en && (valid0 || valid1)) begin
            ptr <= ~grant_id;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    always_comb begin
        grant_id = REQ0;
        if (!valid0 && valid1) begin
            grant_id = REQ1;
        end
    end
`endif

    assign grant0 = en && valid0 && (grant_id == REQ0);
    assign grant1 = en && valid1 && (grant_id == REQ1);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two load/store requesters onto one data memory (policy set by DMEM_ARB_RR_EN).
// Latency: rvalid two cycles after the handshake; at most one transaction every 3 cycles.
// Backpressure: ready only in IDLE to the single granted requester; stalls the other.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic              grant0;
    logic              grant1;
    logic              grant_id;
    logic              grant_any;
    req_id_t           id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              oor;

    dmem_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == IDLE),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant_id (grant_id)
    );

    assign grant_any = grant0 || grant1;

    // Held low during reset so every output reads 0 while rst_n is asserted.
    assign req0_ready = grant0 && rst_n;
    assign req1_ready = grant1 && rst_n;

    assign oor = |addr_q[ADDR_W-1:IDX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= REQ0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                id_q    <= grant_id;
                we_q    <= (grant_id == REQ1) ? req1_we    : req0_we;
                addr_q  <= (grant_id == REQ1) ? req1_addr  : req0_addr;
                wdata_q <= (grant_id == REQ1) ? req1_wdata : req0_wdata;
            end
            // Stores and out-of-range accesses capture 0 so RESP can forward rdata_q as-is.
            if (state == ACCESS) begin
                rdata_q <= (!we_q && !oor) ? mem_rdata : '0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        req0_rvalid = 1'b0;
        req0_rdata  = '0;
        req0_err    = 1'b0;
        req1_rvalid = 1'b0;
        req1_rdata  = '0;
        req1_err    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_read  = !we_q && !oor;
                mem_write = we_q && !oor;
            end
            RESP: begin
                state_nxt = IDLE;
                if (id_q == REQ1) begin
                    req1_rvalid = 1'b1;
                    req1_rdata  = rdata_q;
                    req1_err    = oor;
                end else begin
                    req0_rvalid = 1'b1;
                    req0_rdata  = rdata_q;
                    req0_err    = oor;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses queued at handshake, checked at rvalid.
// Honours DMEM_ARB_RR_EN for the expected arbitration order.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, req0_rvalid, req0_err;
    logic        req1_valid, req1_ready, req1_we, req1_rvalid, req1_err;
    logic [63:0] req0_addr, req0_wdata, req0_rdata;
    logic [63:0] req1_addr, req1_wdata, req1_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic [63:0] tb_mem  [1024];
    logic [63:0] ref_mem [1024];

    typedef struct {
        logic        id;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   ptr    = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req0_err    (req0_err),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .req1_err    (req1_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Memory stand-in: combinational read, write applied mid-cycle while the strobe is up.
    assign mem_rdata = tb_mem[mem_addr[9:0]];
    always @(negedge clk) begin
        if (mem_write) tb_mem[mem_addr[9:0]] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (req0_rvalid || req1_rvalid) begin
            chk("rv_onehot", {63'd0, req0_rvalid & req1_rvalid}, 64'd0);
            if (sb.size() == 0) begin
                chk("rv_unexpected", {62'd0, req1_rvalid, req0_rvalid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id",      {63'd0, req1_rvalid}, {63'd0, mon_e.id});
                chk("rsp_rdata",   req1_rvalid ? req1_rdata : req0_rdata, mon_e.rdata);
                chk("rsp_err",     {63'd0, req1_rvalid ? req1_err : req0_err}, {63'd0, mon_e.err});
                chk("other_rdata", req1_rvalid ? req0_rdata : req1_rdata, 64'd0);
                chk("other_err",   {63'd0, req1_rvalid ? req0_err : req1_err}, 64'd0);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at the negedge after RESP.
    task automatic txn(input bit v0, input bit v1, input bit we0, input bit we1,
                       input logic [63:0] a0, input logic [63:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input bit hold);
        bit          win;
        bit          we;
        bit          oor;
        logic [63:0] a, d;
        exp_t        e;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        #1;
        if (v0 && v1) win = RR_ON ? ptr : 1'b0;
        else          win = v1;
        chk("grant_ready0", {63'd0, req0_ready}, {63'd0, !win});
        chk("grant_ready1", {63'd0, req1_ready}, {63'd0, win});
        ptr = !win;
        we  = win ? we1 : we0;
        a   = win ? a1 : a0;
        d   = win ? d1 : d0;
        oor = (a[63:10] != 54'd0);
        e.id    = win;
        e.err   = oor;
        e.rdata = (we || oor) ? 64'd0 : ref_mem[a[9:0]];
        if (we && !oor) ref_mem[a[9:0]] = d;
        sb.push_back(e);

        @(negedge clk);
        chk("acc_read",  {63'd0, mem_read},  {63'd0, !we && !oor});
        chk("acc_write", {63'd0, mem_write}, {63'd0, we && !oor});
        chk("acc_addr",  mem_addr, a);
        chk("acc_wdata", mem_wdata, d);
        chk("acc_ready", {63'd0, req0_ready | req1_ready}, 64'd0);
        // Disturb the requester side while the transaction is in flight.
        req0_addr = ~req0_addr; req0_we = ~req0_we; req0_wdata = {$urandom, $urandom};
        req1_addr = ~req1_addr; req1_we = ~req1_we; req1_wdata = {$urandom, $urandom};

        @(negedge clk);
        chk("resp_rvalid", {63'd0, win ? req1_rvalid : req0_rvalid}, 64'd1);
        chk("resp_strobe", {63'd0, mem_read | mem_write}, 64'd0);
        chk("resp_addr",   mem_addr, 64'd0);
        chk("resp_ready",  {63'd0, req0_ready | req1_ready}, 64'd0);
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end

        @(negedge clk);
        chk("post_rvalid", {63'd0, req0_rvalid | req1_rvalid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 64'(i * 10);
            ref_mem[i] = 64'(i * 10);
        end
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 64'd1; req0_wdata = 64'd0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 64'd2; req1_wdata = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst_rvalid", {62'd0, req1_rvalid, req0_rvalid}, 64'd0);
        chk("rst_strobe", {62'd0, mem_write, mem_read}, 64'd0);
        chk("rst_addr",   mem_addr, 64'd0);
        chk("rst_rdata",  req0_rdata | req1_rdata, 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        // First grant in the first cycle out of reset.
        txn(1, 0, 0, 0, 64'd1, 64'd0, 64'd0, 64'd0, 0);
        txn(0, 1, 0, 1, 64'd0, 64'd5, 64'd0, 64'hABCD, 0);
        txn(0, 1, 0, 0, 64'd0, 64'd5, 64'd0, 64'd0, 0);
        // Out-of-range load and store: no strobes, err=1, memory untouched.
        txn(1, 0, 0, 0, 64'h400, 64'd0, 64'd0, 64'd0, 0);
        txn(0, 1, 0, 1, 64'd0, 64'h800, 64'd0, 64'h5555, 0);
        txn(1, 0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 0);

        // Both requesters valid back to back.
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0, 0, 64'(10 + i), 64'(20 + i), 64'd0, 64'd0, i != 3);
        end

        // Reset asserted in the middle of ACCESS drops the transaction silently.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 64'd3;
        #1;
        chk("abort_ready", {63'd0, req0_ready}, 64'd1);
        @(negedge clk);
        chk("abort_read", {63'd0, mem_read}, 64'd1);
        rst_n = 1'b0;
        ptr = 1'b0;
        #1;
        chk("abort_strobe", {62'd0, mem_write, mem_read}, 64'd0);
        chk("abort_addr",   mem_addr, 64'd0);
        chk("abort_rdy",    {63'd0, req0_ready}, 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_rvalid", {62'd0, req1_rvalid, req0_rvalid}, 64'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        txn(0, 1, 0, 0, 64'd0, 64'd5, 64'd0, 64'd0, 0);

        for (int i = 0; i < 12; i++) begin
            bit          v0, v1, w0, w1;
            logic [63:0] a0, a1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = 64'($urandom_range(0, 15));
            a1 = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a0 = a0 | 64'h400;
            txn(v0, v1, w0, w1, a0, a1, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, request/memory address width.
REQ-002 Parameter DATA_W, 64, data width.
REQ-003 Parameter IDX_W, 10, number of low address bits that index memory (1024 words).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req0_valid/req1_valid  input  1  requester N has a pending access.
REQ-007 req0_ready/req1_ready  output  1  request N accepted this cycle.
REQ-008 req0_we/req1_we  input  1  1 = store, 0 = load.
REQ-009 req0_addr/req1_addr  input  ADDR_W  word address.
REQ-010 req0_wdata/req1_wdata  input  DATA_W  store data.
REQ-011 req0_rvalid/req1_rvalid  output  1  one-cycle completion pulse for requester N.
REQ-012 req0_rdata/req1_rdata  output  DATA_W  load data, valid with rvalid.
REQ-013 req0_err/req1_err  output  1  out-of-range access flag, valid with rvalid.
REQ-014 mem_read, mem_write  output  1  data-memory strobes.
REQ-015 mem_addr  output  ADDR_W  data-memory address.
REQ-016 mem_wdata  output  DATA_W  data-memory write data.
REQ-017 mem_rdata  input  DATA_W  data-memory combinational read data.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP always, RESP->IDLE always.
REQ-019 In IDLE with any valid, exactly one ready is asserted combinationally (grant); the handshake is valid&&ready.
REQ-020 On handshake, latch granted id, we, addr and wdata; ready is never asserted outside IDLE.
REQ-021 In ACCESS, drive mem_addr/mem_wdata from the latches; assert mem_read (load) or mem_write (store) for exactly one cycle.
REQ-022 Capture mem_rdata at the end of ACCESS; mem strobes, mem_addr and mem_wdata are 0 in IDLE and RESP.
REQ-023 In RESP, pulse rvalid of the granted requester only; rdata = captured data for loads, 0 for stores.
REQ-024 Latency fixed: rvalid two cycles after the handshake cycle; one transaction every 3 cycles maximum.
REQ-025 If addr[ADDR_W-1:IDX_W] is nonzero, suppress both mem strobes in ACCESS; RESP returns err=1, rdata=0.
REQ-026 Requester-side valid/addr/we/wdata changes after the handshake have no effect on the transaction in flight.
REQ-027 rdata and err of the non-granted requester stay 0.

Reset
REQ-028 On rst_n low: state IDLE, all outputs 0, latches cleared, priority pointer to requester 0, in-flight transaction discarded with no rvalid.
REQ-029 The first grant is possible in the first cycle after rst_n deasserts.

Configuration
REQ-030 With DMEM_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the pointer's requester, then point to the other requester after each grant.
REQ-031 Without DMEM_ARB_RR_EN: fixed priority, requester 0 always wins ties; no pointer register exists.

Structure
REQ-032 Package dmem_arb_pkg holds the state enum, requester-id type and the IDLE/ACCESS/RESP encodings.
REQ-033 Grant logic lives in sub-module dmem_rr_arb2 (two-way arbiter, pointer kept inside, macro-controlled).

Verification
REQ-034 Reset, then req0 load addr 1 (memory[1]=10) -> req0_ready in cycle 0, mem_read in cycle 1, req0_rvalid with rdata=10, err=0 in cycle 2.
REQ-035 req1 store addr 5, data 0xABCD, then req1 load addr 5 -> mem_write for one cycle, then rdata=0xABCD.
REQ-036 Both valid every cycle with RR on -> grants alternate 0,1,0,1; with RR off -> only req0 is granted while it stays valid.
REQ-037 req0 load addr 0x400 -> no mem strobe, rvalid with err=1, rdata=0.
REQ-038 rst_n low during ACCESS -> no rvalid, outputs 0 immediately, the next request is served normally.
